// File: rtl/fetch_queue_pkg.sv
// Shared front-end types: functional-unit ids, the BRANCH opcode and the fetch-queue FSM states.
// FETCH_QUEUE_BYPASS_EN is not used here; see fetch_queue.sv.
package fetch_queue_pkg;

    typedef enum logic [1:0] {ALU, LSU, MUL, BU} e_functional_unit;
    localparam int FU_CNT = 4;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic {FQ_RUN, FQ_BRANCH_WAIT} e_fq_state;

    function automatic logic is_branch_opc(input logic [6:0] opc);
        return opc == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// In-order storage for the fetch queue: entry array, wrapping pointers and a separate count.
// The head entry is read combinationally so it is visible the cycle after it is written.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Entries are cleared on reset so the idle head reads as zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_mem[gi] <= '0;
            end else if (i_push && (r_wr_ptr == PW'(gi))) begin
                r_mem[gi] <= i_push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// IFU consumer: polls fetches into fq_fifo and stalls polling after a branch until the BU broadcasts.
// Optional FETCH_QUEUE_BYPASS_EN forwards a fetch straight to dispatch when the queue is empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int INSN_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_ready_i,
    input  logic [INSN_WIDTH-1:0]       fetch_insn_i,
    output logic                        instruction_poll_o,
    input  logic                        bcast_valid_i,
    input  e_functional_unit            bcast_rs_i,
    output logic                        deq_valid_o,
    output logic [INSN_WIDTH-1:0]       deq_insn_o,
    output logic                        deq_is_branch_o,
    input  logic                        deq_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);
    localparam int CW = $clog2(DEPTH+1);

    e_fq_state             r_state;
    e_fq_state             w_state_next;
    logic                  w_bu_bcast;
    logic                  w_full;
    logic                  w_in_branch;
    logic                  w_poll;
    logic                  w_xfer;
    logic                  w_push;
    logic                  w_pop;
    logic [INSN_WIDTH:0]   w_head;
    logic [CW-1:0]         w_count;

    assign w_bu_bcast  = bcast_valid_i && (bcast_rs_i == BU);
    assign w_full      = (w_count == CW'(DEPTH));
    assign w_in_branch = is_branch_opc(fetch_insn_i[6:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= FQ_RUN;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_poll       = 1'b0;
        case (r_state)
            FQ_RUN: begin
                w_poll = fetch_ready_i && !w_full && !w_bu_bcast;
                if (w_poll && w_in_branch) w_state_next = FQ_BRANCH_WAIT;
            end
            FQ_BRANCH_WAIT: begin
                if (w_bu_bcast) w_state_next = FQ_RUN;
            end
            default: w_state_next = FQ_RUN;
        endcase
    end

    // Gate with rst so the IFU never sees a poll while both sides are held in reset.
    assign instruction_poll_o = w_poll && rst;
    assign w_xfer             = instruction_poll_o && fetch_ready_i;
    assign w_pop              = (w_count != '0) && deq_ready_i;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;
    assign w_bypass        = w_xfer && (w_count == '0);
    assign deq_valid_o     = (w_count != '0) || w_bypass;
    assign deq_insn_o      = w_bypass ? fetch_insn_i : w_head[INSN_WIDTH-1:0];
    assign deq_is_branch_o = w_bypass ? w_in_branch  : w_head[INSN_WIDTH];
    assign w_push          = w_xfer && !(w_bypass && deq_ready_i);
`else
    assign deq_valid_o     = (w_count != '0);
    assign deq_insn_o      = w_head[INSN_WIDTH-1:0];
    assign deq_is_branch_o = w_head[INSN_WIDTH];
    assign w_push          = w_xfer;
`endif

    fq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSN_WIDTH + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({w_in_branch, fetch_insn_i}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign count_o = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run against a queue model.
// Build with +define+FETCH_QUEUE_BYPASS_EN to also exercise the bypass path.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] BR_INSN = 32'h00208463;

    logic             clk;
    logic             rst;
    logic             fetch_ready_i;
    logic [31:0]      fetch_insn_i;
    logic             instruction_poll_o;
    logic             bcast_valid_i;
    e_functional_unit bcast_rs_i;
    logic             deq_valid_o;
    logic [31:0]      deq_insn_o;
    logic             deq_is_branch_o;
    logic             deq_ready_i;
    logic [2:0]       count_o;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(DEPTH), .INSN_WIDTH(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_ready_i      (fetch_ready_i),
        .fetch_insn_i       (fetch_insn_i),
        .instruction_poll_o (instruction_poll_o),
        .bcast_valid_i      (bcast_valid_i),
        .bcast_rs_i         (bcast_rs_i),
        .deq_valid_o        (deq_valid_o),
        .deq_insn_o         (deq_insn_o),
        .deq_is_branch_o    (deq_is_branch_o),
        .deq_ready_i        (deq_ready_i),
        .count_o            (count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Reference model: a queue of {is_branch, insn} and a waiting-for-BU flag.
    logic [32:0] mq[$];
    bit          m_wait;

    function automatic bit m_bu();
        return bcast_valid_i && (bcast_rs_i == BU);
    endfunction

    function automatic bit m_poll();
        return rst && !m_wait && fetch_ready_i && (mq.size() < DEPTH) && !m_bu();
    endfunction

    function automatic bit m_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
        return (mq.size() == 0) && m_poll();
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_dvalid();
        return (mq.size() != 0) || m_bypass();
    endfunction

    function automatic logic [32:0] m_dhead();
        if (mq.size() != 0) return mq[0];
        return {fetch_insn_i[6:0] == 7'b1100011, fetch_insn_i};
    endfunction

    // Advance one clock edge and update the model from the inputs present before the edge.
    task automatic tick();
        bit          xfer, pop, byp_taken, bu, was_wait;
        logic [32:0] ent;
        xfer      = m_poll();
        pop       = m_dvalid() && deq_ready_i;
        byp_taken = m_bypass() && deq_ready_i;
        bu        = m_bu();
        was_wait  = m_wait;
        ent       = {fetch_insn_i[6:0] == 7'b1100011, fetch_insn_i};
        @(posedge clk);
        #1;
        if (!byp_taken) begin
            if (pop) void'(mq.pop_front());
            if (xfer) mq.push_back(ent);
        end
        if (was_wait && bu) m_wait = 1'b0;
        if (xfer && ent[32]) m_wait = 1'b1;
    endtask

    task automatic drain();
        fetch_ready_i = 1'b0;
        bcast_valid_i = 1'b0;
        deq_ready_i   = 1'b1;
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) tick();
        #1;
        checks++;
        if (count_o !== 3'd0) begin
            errors++;
            $display("FAIL drain_count got %0d exp 0", count_o);
        end
        deq_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; fetch_ready_i = 1'b1; fetch_insn_i = 32'h13;
        bcast_valid_i = 1'b0; bcast_rs_i = ALU; deq_ready_i = 1'b0;
        mq.delete(); m_wait = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
        checks++;
        if (deq_valid_o !== 1'b0) begin errors++; $display("FAIL reset_deq_valid got %b exp 0", deq_valid_o); end
        checks++;
        if (deq_insn_o !== 32'h0) begin errors++; $display("FAIL reset_deq_insn got %h exp 0", deq_insn_o); end
        checks++;
        if (deq_is_branch_o !== 1'b0) begin errors++; $display("FAIL reset_deq_branch got %b exp 0", deq_is_branch_o); end
        checks++;
        if (instruction_poll_o !== 1'b0) begin errors++; $display("FAIL reset_poll got %b exp 0", instruction_poll_o); end
        fetch_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        logic [31:0] prev;
        prev = '0;
        fetch_ready_i = 1'b1;
        deq_ready_i   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fetch_insn_i = 32'h00000013 | (32'(i) << 20) | (32'(i) << 7);
            #1;
            checks++;
            if (instruction_poll_o !== 1'b1) begin
                errors++; $display("FAIL stream_poll[%0d] got %b exp 1", i, instruction_poll_o);
            end
            if (i > 0) begin
                checks++;
                if (deq_valid_o !== 1'b1 || deq_insn_o !== prev) begin
                    errors++;
                    $display("FAIL stream_deq[%0d] got v=%b %h exp v=1 %h", i, deq_valid_o, deq_insn_o, prev);
                end
`ifndef FETCH_QUEUE_BYPASS_EN
                checks++;
                if (count_o !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count_o); end
`endif
            end
            prev = fetch_insn_i;
            tick();
        end
    endtask

    task automatic test_fill();
        int xfers;
        drain();
        xfers = 0;
        fetch_ready_i = 1'b1;
        deq_ready_i   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            fetch_insn_i = 32'h00100093 + (32'(i) << 20);
            #1;
            if (instruction_poll_o === 1'b1) xfers++;
            tick();
        end
        checks++;
        if (xfers != DEPTH) begin errors++; $display("FAIL fill_xfers got %0d exp %0d", xfers, DEPTH); end
        checks++;
        if (count_o !== 3'(DEPTH)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count_o, DEPTH); end
        deq_ready_i = 1'b1;
        #1;
        checks++;
        if (instruction_poll_o !== 1'b0) begin errors++; $display("FAIL fill_poll_full got %b exp 0", instruction_poll_o); end
        checks++;
        if (deq_insn_o !== mq[0][31:0]) begin errors++; $display("FAIL fill_head got %h exp %h", deq_insn_o, mq[0][31:0]); end
        tick();
        deq_ready_i = 1'b0;
        #1;
        checks++;
        if (count_o !== 3'(DEPTH - 1)) begin errors++; $display("FAIL fill_pop_count got %0d exp %0d", count_o, DEPTH - 1); end
        checks++;
        if (instruction_poll_o !== 1'b1) begin errors++; $display("FAIL fill_poll_resume got %b exp 1", instruction_poll_o); end
        fetch_ready_i = 1'b0;
    endtask

    task automatic test_branch_wait();
        drain();
        fetch_ready_i = 1'b1;
        fetch_insn_i  = BR_INSN;
        #1;
        checks++;
        if (instruction_poll_o !== 1'b1) begin errors++; $display("FAIL br_poll_take got %b exp 1", instruction_poll_o); end
        tick();
        fetch_insn_i = 32'h00000013;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if (instruction_poll_o !== 1'b0) begin errors++; $display("FAIL br_wait_poll[%0d] got %b exp 0", c, instruction_poll_o); end
            if (c == 1) begin
                checks++;
                if (deq_valid_o !== 1'b1 || deq_is_branch_o !== 1'b1 || deq_insn_o !== BR_INSN) begin
                    errors++;
                    $display("FAIL br_head got v=%b br=%b %h exp v=1 br=1 %h", deq_valid_o, deq_is_branch_o, deq_insn_o, BR_INSN);
                end
            end
            tick();
        end
        bcast_valid_i = 1'b1;
        bcast_rs_i    = BU;
        #1;
        checks++;
        if (instruction_poll_o !== 1'b0) begin errors++; $display("FAIL br_bcast_cycle_poll got %b exp 0", instruction_poll_o); end
        tick();
        bcast_valid_i = 1'b0;
        #1;
        checks++;
        if (instruction_poll_o !== 1'b1) begin errors++; $display("FAIL br_resume_poll got %b exp 1", instruction_poll_o); end
        fetch_ready_i = 1'b0;
    endtask

    task automatic test_bcast_gate();
        drain();
        fetch_ready_i = 1'b1;
        fetch_insn_i  = 32'h00000013;
        bcast_valid_i = 1'b1;
        bcast_rs_i    = BU;
        #1;
        checks++;
        if (instruction_poll_o !== 1'b0) begin errors++; $display("FAIL gate_bu_poll got %b exp 0", instruction_poll_o); end
        tick();
        bcast_rs_i = LSU;
        #1;
        checks++;
        if (instruction_poll_o !== 1'b1) begin errors++; $display("FAIL gate_other_poll got %b exp 1", instruction_poll_o); end
        tick();
        bcast_valid_i = 1'b0;
        fetch_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        drain();
        fetch_ready_i = 1'b1;
        fetch_insn_i = 32'h00000013; tick();
        fetch_insn_i = 32'h00100093; tick();
        fetch_insn_i = BR_INSN;      tick();
        fetch_insn_i = 32'h00000013;
        #1;
        checks++;
        if (count_o !== 3'd3 || instruction_poll_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre got count=%0d poll=%b exp count=3 poll=0", count_o, instruction_poll_o);
        end
        #1;
        rst = 1'b0;
        mq.delete(); m_wait = 1'b0;
        #1;
        checks++;
        if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || instruction_poll_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got count=%0d dv=%b poll=%b exp 0 0 0", count_o, deq_valid_o, instruction_poll_o);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if (instruction_poll_o !== 1'b1) begin errors++; $display("FAIL rstmid_resume_poll got %b exp 1", instruction_poll_o); end
        fetch_ready_i = 1'b0;
    endtask

`ifdef FETCH_QUEUE_BYPASS_EN
    task automatic test_bypass();
        drain();
        deq_ready_i   = 1'b1;
        fetch_ready_i = 1'b1;
        fetch_insn_i  = 32'h00500113;
        #1;
        checks++;
        if (deq_valid_o !== 1'b1 || deq_insn_o !== 32'h00500113) begin
            errors++; $display("FAIL bypass_same_cycle got v=%b %h exp v=1 00500113", deq_valid_o, deq_insn_o);
        end
        tick();
        fetch_ready_i = 1'b0;
        #1;
        checks++;
        if (count_o !== 3'd0) begin errors++; $display("FAIL bypass_count got %0d exp 0", count_o); end
    endtask
`endif

    task automatic test_random();
        logic [32:0] h;
        for (int i = 0; i < 400; i++) begin
            fetch_ready_i = ($urandom_range(0, 3) != 0);
            fetch_insn_i  = $urandom();
            if ($urandom_range(0, 5) == 0) fetch_insn_i[6:0] = 7'b1100011;
            bcast_valid_i = ($urandom_range(0, 3) == 0);
            bcast_rs_i    = e_functional_unit'($urandom_range(0, 3));
            deq_ready_i   = ($urandom_range(0, 2) != 0);
            #1;
            h = m_dhead();
            checks++;
            if (instruction_poll_o !== m_poll()) begin
                errors++; $display("FAIL rnd_poll[%0d] got %b exp %b", i, instruction_poll_o, m_poll());
            end
            checks++;
            if (count_o !== 3'(mq.size())) begin
                errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, count_o, mq.size());
            end
            checks++;
            if (deq_valid_o !== m_dvalid()) begin
                errors++; $display("FAIL rnd_dvalid[%0d] got %b exp %b", i, deq_valid_o, m_dvalid());
            end
            if (m_dvalid()) begin
                checks++;
                if (deq_insn_o !== h[31:0] || deq_is_branch_o !== h[32]) begin
                    errors++;
                    $display("FAIL rnd_head[%0d] got br=%b %h exp br=%b %h", i, deq_is_branch_o, deq_insn_o, h[32], h[31:0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill();
        test_branch_wait();
        test_bcast_gate();
        test_reset_mid();
`ifdef FETCH_QUEUE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Consumer end of the IFU fetch handshake. Polls the IFU, captures fetched instructions into a small in-order FIFO tagged with a branch flag, and presents them to dispatch with a valid/ready handshake. Enforces the front-end branch rule: it stops polling after accepting a conditional branch until the branch unit broadcasts, and it never polls in a cycle with a BU broadcast.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- INSN_WIDTH, 32, instruction width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- fetch_ready_i  in  1  IFU has a valid instruction on fetch_insn_i
- fetch_insn_i  in  INSN_WIDTH  instruction from IFU
- instruction_poll_o  out  1  take fetch_insn_i this cycle; transfer = poll & fetch_ready_i
- bcast_valid_i  in  1  CDB broadcast valid
- bcast_rs_i  in  e_functional_unit  broadcasting unit
- deq_valid_o  out  1  head entry valid
- deq_insn_o  out  INSN_WIDTH  head instruction
- deq_is_branch_o  out  1  head opcode is BRANCH
- deq_ready_i  in  1  dispatch accepts head; pop = deq_valid_o & deq_ready_i
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Branch detect: is_branch = (fetch_insn_i[6:0] == OPC_BRANCH, 7'b1100011); stored alongside the instruction.
- bu_bcast = bcast_valid_i & (bcast_rs_i == BU).
- State machine e_fq_state:
  - FQ_RUN: instruction_poll_o = fetch_ready_i & (count < DEPTH) & !bu_bcast. A transfer whose instruction is_branch moves to FQ_BRANCH_WAIT; otherwise stay.
  - FQ_BRANCH_WAIT: instruction_poll_o = 0. On bu_bcast, go to FQ_RUN at the next edge. Polling resumes the cycle after the broadcast, never in the broadcast cycle.
- A bu_bcast in FQ_RUN is ignored apart from suppressing that cycle's poll.
- Full check uses the registered count only. A pop in the same cycle does not free a slot for that cycle's poll.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is tracked separately to distinguish full from empty.
- Pop when empty is impossible because deq_valid_o = (count != 0).
- Reset mid-operation discards all entries and any pending branch wait. The IFU is reset by the same rst.

## Timing
- Reset values: count_o=0, deq_valid_o=0, deq_insn_o=0, deq_is_branch_o=0, state FQ_RUN, pointers 0.
- instruction_poll_o is combinational from registered state, count, fetch_ready_i and bu_bcast. It is 0 while rst is asserted.
- Enqueue latency: an instruction transferred at edge N is visible on deq_* in cycle N+1 (no-bypass build).
- The state change to FQ_BRANCH_WAIT takes effect at the same edge as the branch transfer, so there is no poll in cycle N+1.
- Throughput: 1 instruction/cycle sustained while not full and not in FQ_BRANCH_WAIT.
- deq_insn_o and deq_is_branch_o are driven from storage, valid only when deq_valid_o=1, and hold while not popped.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count==0 and a transfer occurs, deq_valid_o/deq_insn_o/deq_is_branch_o reflect fetch_insn_i combinationally in the same cycle.
  - If deq_ready_i=1 in that cycle, the instruction is not written to the FIFO and count stays 0.
  - The branch-wait transition is unchanged.
- FETCH_QUEUE_BYPASS_EN undefined: always 1-cycle latency through storage. deq_* depend only on registered state.

## Structure
- Shared types package gets:
  - OPC_BRANCH (7'b1100011), used by both the IFU and this block.
  - typedef enum e_fq_state {FQ_RUN, FQ_BRANCH_WAIT}.
- e_functional_unit, BU and FU_CNT already live in the types package.
- Sub-module fq_fifo holds the storage, pointers and count: parameters DEPTH and WIDTH=INSN_WIDTH+1; push/pop ports plus count. The control FSM and bypass mux stay in fetch_queue.

## Test plan
- Streaming: fetch_ready_i=1, non-branch insns 0x00000013, 0x00100093, …, deq_ready_i=1 → poll every cycle; each insn appears on deq_insn_o one cycle after its transfer, in order; count_o stays at 1.
- Fill: deq_ready_i=0, fetch_ready_i=1 → exactly 4 transfers, count_o=4, poll drops to 0. Raise deq_ready_i for one cycle → pop at that edge, count_o=3, poll reasserts the following cycle.
- Branch wait: transfer 0x00208463 → deq_is_branch_o=1 at its turn. Poll stays 0 for 5 cycles. BU broadcast in cycle 6 → poll still 0 in cycle 6, poll=1 in cycle 7.
- Broadcast gating in FQ_RUN: bcast_valid_i=1, bcast_rs_i=BU with fetch_ready_i=1 → poll=0 that cycle only. Same with bcast_rs_i≠BU → poll=1.
- Reset mid-operation: count_o=3 and FQ_BRANCH_WAIT, drive rst=0 asynchronously → count_o=0, deq_valid_o=0, poll=0 immediately. Release → polling on the next cycle with fetch_ready_i=1.
- Bypass (FETCH_QUEUE_BYPASS_EN): empty queue, deq_ready_i=1, fetch_insn_i=0x00500113 → deq_valid_o=1 with that insn in the same cycle; count_o remains 0.
